// File: rtl/execute_mdu_pkg.sv
// rtl/execute_mdu_pkg.sv - Shared encodings for the execute stage and its multiply/divide unit
package execute_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD   = 4'd0,
    ALU_OP_SUB   = 4'd1,
    ALU_OP_AND   = 4'd2,
    ALU_OP_OR    = 4'd3,
    ALU_OP_XOR   = 4'd4,
    ALU_OP_SLL   = 4'd5,
    ALU_OP_SRL   = 4'd6,
    ALU_OP_SRA   = 4'd7,
    ALU_OP_SLT   = 4'd8,
    ALU_OP_SLTU  = 4'd9,
    ALU_OP_PASSB = 4'd10
  } alu_op_e;

  // Branches test the ALU zero flag; use ALU_OP_SUB for compares.
  typedef enum logic [1:0] {NPC_PC4, NPC_BEQ, NPC_BNE, NPC_JMP} npc_op_e;
  typedef enum logic {NPCO_EXT, NPCO_ALU} npco_sel_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HOLD} mdu_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// rtl/execute_mdu_if.sv - Op-in / result-out handshake bundle of the execute stage
interface execute_mdu_if
  import execute_mdu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  alu_op_e         alu_op;
  logic            md_en;
  md_op_e          md_op;
  npc_op_e         npc_op;
  npco_sel_e       npco_sel;
  logic [XLEN-1:0] aluA;
  logic [XLEN-1:0] aluB;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ext;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc4;
  logic            is_jump;
  logic            busy;

  modport master (
    output in_valid, flush, alu_op, md_en, md_op, npc_op, npco_sel,
           aluA, aluB, pc, ext, out_ready,
    input  in_ready, out_valid, result, npc, pc4, is_jump, busy
  );

  modport slave (
    input  in_valid, flush, alu_op, md_en, md_op, npc_op, npco_sel,
           aluA, aluB, pc, ext, out_ready,
    output in_ready, out_valid, result, npc, pc4, is_jump, busy
  );
endinterface

// File: rtl/execute_mdu_div.sv
// rtl/execute_mdu_div.sv - Iterative restoring divider on magnitudes, UNROLL quotient bits per cycle
module ex_mdu_div #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_o
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [XLEN-1:0] nxt_rem, nxt_quo, src_div;
  logic [XLEN:0]   trial;
  logic [CW-1:0]   cnt_q;
  logic            run_q;

  // The start cycle already retires the first UNROLL bits from the raw operands.
  always_comb begin
    nxt_rem = start_i ? '0 : rem_q;
    nxt_quo = start_i ? dividend_i : quo_q;
    src_div = start_i ? divisor_i : div_q;
    trial   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      trial   = {nxt_rem, nxt_quo[XLEN-1]};
      nxt_quo = {nxt_quo[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, src_div}) begin
        trial      = trial - {1'b0, src_div};
        nxt_quo[0] = 1'b1;
      end
      nxt_rem = trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || kill_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (start_i) begin
      rem_q <= nxt_rem;
      quo_q <= nxt_quo;
      div_q <= divisor_i;
      cnt_q <= CW'(STEPS - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        rem_q <= nxt_rem;
        quo_q <= nxt_quo;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign done_o = run_q && (cnt_q == '0);
endmodule

// File: rtl/execute_mdu.sv
// rtl/execute_mdu.sv - Execute stage: ALU, next-PC resolution and iterative multiply/divide
module execute_mdu
  import execute_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_UNROLL = 1,
  parameter int MUL_LAT    = 2
) (
  input logic          cpu_clk,
  input logic          cpu_rst_n,
  execute_mdu_if.slave io
);
  localparam int              SHW  = $clog2(XLEN);
  localparam int              CW   = $clog2(MUL_LAT + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q;
  md_op_e          md_op_q;
  logic            out_valid_q, is_jump_q, q_neg_q, r_neg_q;
  logic [XLEN-1:0] result_q, npc_q, pc4_q, pend_q, op_a_q, op_b_q;
  logic [CW-1:0]   mcnt_q;

  logic            out_free, in_ready, accept, fin;
  logic [XLEN-1:0] alu_res, offset, pc4_w, npc_w, fin_res;
  md_op_e          mul_op;
  logic [XLEN-1:0] mul_a, mul_b, mul_res;
  logic [2*XLEN-1:0] mul_ax, mul_bx, mul_prod;
  logic            d_sgn, sa, sb, div0, ovf, div_start, d_done;
  logic [XLEN-1:0] a_mag, b_mag, early_res, d_quo, d_rem, div_res;

  assign out_free = !out_valid_q || io.out_ready;
  assign in_ready = (state_q == S_IDLE) && out_free && !io.flush;
  assign accept   = io.in_valid && in_ready;

  always_comb begin
    case (io.alu_op)
      ALU_OP_ADD:   alu_res = io.aluA + io.aluB;
      ALU_OP_SUB:   alu_res = io.aluA - io.aluB;
      ALU_OP_AND:   alu_res = io.aluA & io.aluB;
      ALU_OP_OR:    alu_res = io.aluA | io.aluB;
      ALU_OP_XOR:   alu_res = io.aluA ^ io.aluB;
      ALU_OP_SLL:   alu_res = io.aluA << io.aluB[SHW-1:0];
      ALU_OP_SRL:   alu_res = io.aluA >> io.aluB[SHW-1:0];
      ALU_OP_SRA:   alu_res = $unsigned($signed(io.aluA) >>> io.aluB[SHW-1:0]);
      ALU_OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(io.aluA) < $signed(io.aluB)};
      ALU_OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, io.aluA < io.aluB};
      ALU_OP_PASSB: alu_res = io.aluB;
      default:      alu_res = '0;
    endcase
  end

  assign offset = (io.npco_sel == NPCO_ALU) ? alu_res : io.ext;
  assign pc4_w  = io.pc + XLEN'(4);

  always_comb begin
    case (io.npc_op)
      NPC_BEQ: npc_w = (alu_res == '0) ? io.pc + offset : pc4_w;
      NPC_BNE: npc_w = (alu_res != '0) ? io.pc + offset : pc4_w;
      NPC_JMP: npc_w = io.pc + offset;
      default: npc_w = pc4_w;
    endcase
  end

  // Product is taken from the live inputs in IDLE (MUL_LAT == 1) and from latched operands otherwise.
  assign mul_op   = (state_q == S_IDLE) ? io.md_op : md_op_q;
  assign mul_a    = (state_q == S_IDLE) ? io.aluA : op_a_q;
  assign mul_b    = (state_q == S_IDLE) ? io.aluB : op_b_q;
  assign mul_ax   = {{XLEN{(mul_op == MD_MULH || mul_op == MD_MULHSU) && mul_a[XLEN-1]}}, mul_a};
  assign mul_bx   = {{XLEN{(mul_op == MD_MULH) && mul_b[XLEN-1]}}, mul_b};
  assign mul_prod = mul_ax * mul_bx;
  assign mul_res  = (mul_op == MD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  assign d_sgn     = (io.md_op == MD_DIV) || (io.md_op == MD_REM);
  assign sa        = d_sgn && io.aluA[XLEN-1];
  assign sb        = d_sgn && io.aluB[XLEN-1];
  assign a_mag     = sa ? -io.aluA : io.aluA;
  assign b_mag     = sb ? -io.aluB : io.aluB;
  assign div0      = (io.aluB == '0);
  assign ovf       = d_sgn && (io.aluA == XMIN) && (io.aluB == '1);
  assign early_res = div0 ? (md_is_rem(io.md_op) ? io.aluA : '1)
                          : (md_is_rem(io.md_op) ? '0 : io.aluA);
  assign div_start = accept && io.md_en && md_is_div(io.md_op) && !div0 && !ovf;

  ex_mdu_div #(.XLEN(XLEN), .UNROLL(DIV_UNROLL)) u_div (
    .clk_i      (cpu_clk),
    .rst_ni     (cpu_rst_n),
    .start_i    (div_start),
    .kill_i     (io.flush),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_o      (d_quo),
    .rem_o      (d_rem),
    .done_o     (d_done)
  );

  assign div_res = md_is_rem(md_op_q) ? (r_neg_q ? -d_rem : d_rem) : (q_neg_q ? -d_quo : d_quo);
  assign fin     = ((state_q == S_MUL) && (mcnt_q == CW'(1))) || ((state_q == S_DIV) && d_done);
  assign fin_res = (state_q == S_MUL) ? mul_res : div_res;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state_q     <= S_IDLE;
      md_op_q     <= MD_MUL;
      out_valid_q <= 1'b0;
      is_jump_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      result_q    <= '0;
      npc_q       <= '0;
      pc4_q       <= '0;
      pend_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      mcnt_q      <= '0;
    end else if (io.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      mcnt_q      <= '0;
    end else begin
      if (out_free) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          pc4_q <= pc4_w;
          if (!io.md_en) begin
            result_q    <= alu_res;
            npc_q       <= npc_w;
            is_jump_q   <= (npc_w != pc4_w);
            out_valid_q <= 1'b1;
          end else begin
            npc_q     <= pc4_w;
            is_jump_q <= 1'b0;
            md_op_q   <= io.md_op;
            op_a_q    <= io.aluA;
            op_b_q    <= io.aluB;
            q_neg_q   <= sa ^ sb;
            r_neg_q   <= sa;
            if (md_is_div(io.md_op)) begin
              if (div0 || ovf) begin
                result_q    <= early_res;
                out_valid_q <= 1'b1;
              end else begin
                state_q <= S_DIV;
              end
            end else if (MUL_LAT == 1) begin
              result_q    <= mul_res;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_MUL;
              mcnt_q  <= CW'(MUL_LAT - 1);
            end
          end
        end
        S_MUL: mcnt_q <= fin ? '0 : mcnt_q - 1'b1;
        S_HOLD: if (out_free) begin
          result_q    <= pend_q;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: ;
      endcase
      // A finished MDU op parks in HOLD until the previous result has drained.
      if (fin) begin
        if (out_free) begin
          result_q    <= fin_res;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end else begin
          pend_q  <= fin_res;
          state_q <= S_HOLD;
        end
      end
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.npc       = npc_q;
  assign io.pc4       = pc4_q;
  assign io.is_jump   = is_jump_q;
  assign io.busy      = (state_q != S_IDLE);
endmodule

// File: doc/execute_mdu.md
Name: execute_mdu

Overview:
Parametrised successor of the single-cycle execute stage: ALU, next-PC/branch resolution, plus an iterative multiply/divide unit (RV32M semantics, generalised to XLEN). Sits between the ID/EX and EX/MEM pipeline registers. Uses valid/ready handshakes on both sides so multi-cycle MDU ops stall the front end. Result and branch outcome are registered; branch outcome still feeds hazard/flush logic.

Parameters:
XLEN, 32, datapath width (32 or 64)
DIV_UNROLL, 1, quotient bits retired per divide cycle (1, 2 or 4; XLEN divisible by it)
MUL_LAT, 2, multiply latency in cycles from accept to out_valid (>=1)

Ports:
cpu_clk  in  1  clock
cpu_rst_n  in  1  synchronous reset, active-low
in_valid  in  1  upstream op present
in_ready  out  1  block accepts op this cycle
flush  in  1  kill in-flight and pending-output op
alu_op  in  4  ALU operation (shared ALU_OP encoding)
md_en  in  1  op is multiply/divide; alu_op ignored
md_op  in  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
npc_op  in  2  next-PC mode (shared NPC_* encoding)
npco_sel  in  1  branch offset source: ALU result vs ext
aluA  in  XLEN  operand A
aluB  in  XLEN  operand B
pc  in  XLEN  PC of op
ext  in  XLEN  immediate
out_valid  out  1  registered result valid
out_ready  in  1  downstream accepts
result  out  XLEN  ALU or MDU result
npc  out  XLEN  resolved next PC
pc4  out  XLEN  pc+4
is_jump  out  1  npc != pc4; meaningful only with out_valid
busy  out  1  MDU FSM not IDLE

Behaviour:
- Reset (cpu_rst_n=0 at cpu_clk edge): out_valid=0, busy=0, is_jump=0, result/npc/pc4=0, FSM=IDLE; overrides all other inputs, including mid-divide.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
- FSM: IDLE, MUL, DIV, HOLD.
- Non-MDU accept: ALU, NPC and is_jump computed combinationally, registered; out_valid=1 next cycle (latency 1). Branch flag f from ALU as before; offset = npco_sel ? ALU result : ext.
- MDU ops: npc=pc4, is_jump=0.
- MUL* accept: IDLE->MUL; counter loaded MUL_LAT-1; result registered when counter hits 0; out_valid asserted MUL_LAT cycles after accept. MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the 2*XLEN signed*signed / signed*unsigned / unsigned*unsigned product.
- DIV* accept: operands converted to magnitude for signed ops; restoring divide, DIVUNROLL bits/cycle; XLEN/DIV_UNROLL iteration cycles plus 1 sign-fixup cycle; out_valid at accept+XLEN/DIV_UNROLL+1. Quotient sign = signA^signB; remainder sign = signA.
- Divide by zero: 1-cycle early out: DIV/DIVU quotient = all ones, REM/REMU = aluA.
- Signed overflow (aluA = -2^(XLEN-1), aluB = -1, DIV/REM): 1-cycle early out: quotient = aluA, remainder = 0.
- Completion while out_valid && !out_ready: FSM->HOLD, busy stays 1, result kept until prior output drains; output registers update only when !out_valid || out_ready.
- out_valid && !out_ready: all outputs stable.
- flush: next edge out_valid=0, FSM=IDLE, counters cleared; op presented same cycle not accepted. Flush has priority over completion; reset has priority over flush.
- busy = state != IDLE.

Decomposition:
- Shared package/defines: ALU_OP_*, NPC_*, NPCO_*, MD_* funct3 codes, FSM state encoding.
- Sub-module: ex_mdu_div (iterative divider, DIV_UNROLL param, start/done handshake). ALU and NPC instantiated as existing ex_alu / if_npc. Multiplier inline.

Test Plan:
- ADD 5+7, out_ready=1 -> out_valid one cycle later, result=12, is_jump=0, npc=pc+4.
- BEQ aluA=aluB=3, pc=0x100, ext=0x20 -> npc=0x120, is_jump=1.
- MULH 0x80000000*0x80000000 (XLEN=32) -> 0x40000000 after 2 cycles; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; in_ready=0 while busy.
- DIV -7/2 -> -3, REM -7/2 -> -1, out_valid at accept+33 (DIV_UNROLL=1); DIVU 7/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, 1 cycle.
- DIVU 100/7 with out_ready=0 on completion -> HOLD, result 14 stable; out_ready=1 -> drains, in_ready returns next cycle.
- flush 10 cycles into DIV -> out_valid never asserts for it, busy=0 next cycle; cpu_rst_n=0 mid-MUL -> all outputs 0 next edge.
